// File: rtl/clk_rand_core_pkg.sv
// clk_rand_core_pkg: maximal-length LFSR tap masks and the default seed shared by the clock/random core.
package clk_rand_core_pkg;
   localparam logic [31:0] SEED = 32'd30504031;
   function automatic logic [31:0] tap(input int t);
      return 32'd1 << (t - 1);
   endfunction
   function automatic logic [31:0] lfsr_taps(input int n);
      case (n)
         3:       return tap(3) | tap(2);
         4:       return tap(4) | tap(3);
         5:       return tap(5) | tap(3);
         6:       return tap(6) | tap(5);
         7:       return tap(7) | tap(6);
         8:       return tap(8) | tap(6) | tap(5) | tap(4);
         9:       return tap(9) | tap(5);
         10:      return tap(10) | tap(7);
         11:      return tap(11) | tap(9);
         12:      return tap(12) | tap(6) | tap(4) | tap(1);
         13:      return tap(13) | tap(4) | tap(3) | tap(1);
         14:      return tap(14) | tap(5) | tap(3) | tap(1);
         15:      return tap(15) | tap(14);
         16:      return tap(16) | tap(15) | tap(13) | tap(4);
         17:      return tap(17) | tap(14);
         18:      return tap(18) | tap(11);
         19:      return tap(19) | tap(6) | tap(2) | tap(1);
         20:      return tap(20) | tap(17);
         21:      return tap(21) | tap(19);
         22:      return tap(22) | tap(21);
         23:      return tap(23) | tap(18);
         24:      return tap(24) | tap(23) | tap(22) | tap(17);
         25:      return tap(25) | tap(22);
         26:      return tap(26) | tap(6) | tap(2) | tap(1);
         27:      return tap(27) | tap(5) | tap(2) | tap(1);
         28:      return tap(28) | tap(25);
         29:      return tap(29) | tap(27);
         30:      return tap(30) | tap(6) | tap(4) | tap(1);
         31:      return tap(31) | tap(28);
         default: return tap(32) | tap(22) | tap(2) | tap(1);
      endcase
   endfunction
endpackage

// File: rtl/clk_rand_core_toggle_divider.sv
// toggle_divider: square wave toggling every HALF cycles with a strobe on each rising transition.
module toggle_divider #(
   parameter int HALF = 2
) (
   input  logic in_clk,
   input  logic reset,
   output logic clk_o,
   output logic tick_o
);
   localparam int W = $clog2(HALF + 1);
   logic [W-1:0] cnt;
   logic last;
   assign last = cnt == W'(HALF - 1);
   always_ff @(posedge in_clk) begin
      if (reset) begin
         cnt    <= '0;
         clk_o  <= 1'b0;
         tick_o <= 1'b0;
      end else begin
         cnt    <= last ? '0 : cnt + 1'b1;
         clk_o  <= last ? ~clk_o : clk_o;
         tick_o <= last & ~clk_o;
      end
   end
endmodule

// File: rtl/clk_rand_core.sv
// clk_rand_core: pixel clock, slow programmable wave and an XNOR LFSR stepping on the slow wave.
module clk_rand_core
   import clk_rand_core_pkg::*;
#(
   parameter int PIX_HALF   = 2,
   parameter int DIV_NUMBER = 50000,
   parameter int NUM_BITS   = 25
) (
   input  logic                in_clk,
   input  logic                reset,
   input  logic                lfsr_en,
   input  logic                seed_dv,
   input  logic [NUM_BITS-1:0] seed_data,
   output logic                pix_clk,
   output logic                pix_tick,
   output logic                div_clk,
   output logic                div_tick,
   output logic [NUM_BITS-1:0] lfsr_data,
   output logic                lfsr_done
);
   localparam logic [31:0] TAPS = lfsr_taps(NUM_BITS);
   logic fb;
   toggle_divider #(.HALF(PIX_HALF)) u_pix (
      .in_clk(in_clk), .reset(reset), .clk_o(pix_clk), .tick_o(pix_tick)
   );
   toggle_divider #(.HALF(DIV_NUMBER)) u_div (
      .in_clk(in_clk), .reset(reset), .clk_o(div_clk), .tick_o(div_tick)
   );
   assign fb        = ~^(lfsr_data & TAPS[NUM_BITS-1:0]);
   assign lfsr_done = lfsr_data == seed_data;
   always_ff @(posedge in_clk) begin
      if (reset)
         lfsr_data <= '0;
      else if (seed_dv)
         lfsr_data <= seed_data;
      else if (lfsr_en && div_tick)
         lfsr_data <= {lfsr_data[NUM_BITS-2:0], fb};
   end
endmodule

// File: tb/tb_clk_rand_core.sv
// tb_clk_rand_core: randomized and directed checks of dividers and LFSR against an arithmetic reference model.
module tb_clk_rand_core;
   logic in_clk = 1'b0, reset = 1'b1, lfsr_en = 1'b0, seed_dv = 1'b0;
   logic [24:0] seed25 = '0;
   logic [4:0]  seed5 = '0;
   logic pix_a, ptick_a, dclk_a, dtick_a, done_a;
   logic pix_b, ptick_b, dclk_b, dtick_b, done_b;
   logic [24:0] data_a;
   logic [4:0]  data_b;
   int n = 0, n_chk = 0, n_fail = 0;
   logic [31:0] m25 = '0, m5 = '0;
   always #5 in_clk = ~in_clk;
   clk_rand_core #(.PIX_HALF(2), .DIV_NUMBER(3), .NUM_BITS(25)) u_a (
      .in_clk(in_clk), .reset(reset), .lfsr_en(lfsr_en), .seed_dv(seed_dv), .seed_data(seed25),
      .pix_clk(pix_a), .pix_tick(ptick_a), .div_clk(dclk_a), .div_tick(dtick_a),
      .lfsr_data(data_a), .lfsr_done(done_a)
   );
   clk_rand_core #(.PIX_HALF(2), .DIV_NUMBER(1), .NUM_BITS(5)) u_b (
      .in_clk(in_clk), .reset(reset), .lfsr_en(lfsr_en), .seed_dv(seed_dv), .seed_data(seed5),
      .pix_clk(pix_b), .pix_tick(ptick_b), .div_clk(dclk_b), .div_tick(dtick_b),
      .lfsr_data(data_b), .lfsr_done(done_b)
   );
   function automatic logic wave_at(int k, int half);
      return ((k / half) % 2) == 1;
   endfunction
   function automatic logic tick_at(int k, int half);
      return k > 0 && (k % half) == 0 && ((k / half) % 2) == 1;
   endfunction
   function automatic logic [31:0] ref_step(logic [31:0] v, int nb, int ta, int tb);
      logic [63:0] mask;
      logic fb;
      mask = (64'd1 << nb) - 64'd1;
      fb   = !(v[ta-1] ^ v[tb-1]);
      return 32'(((64'(v) << 1) | 64'(fb)) & mask);
   endfunction
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      logic t25, t5;
      t25 = tick_at(n, 3);
      t5  = tick_at(n, 1);
      @(posedge in_clk);
      if (reset) begin
         n = 0; m25 = '0; m5 = '0;
      end else begin
         n++;
         if (seed_dv) begin
            m25 = 32'(seed25); m5 = 32'(seed5);
         end else if (lfsr_en) begin
            if (t25) m25 = ref_step(m25, 25, 25, 22);
            if (t5)  m5  = ref_step(m5, 5, 5, 3);
         end
      end
      #1;
      chk("pix_clk", 32'(pix_a), 32'(wave_at(n, 2)));
      chk("pix_tick", 32'(ptick_a), 32'(tick_at(n, 2)));
      chk("div_clk", 32'(dclk_a), 32'(wave_at(n, 3)));
      chk("div_tick", 32'(dtick_a), 32'(tick_at(n, 3)));
      chk("lfsr25", 32'(data_a), m25);
      chk("done25", 32'(done_a), 32'(m25 == 32'(seed25)));
      chk("div1_clk", 32'(dclk_b), 32'(wave_at(n, 1)));
      chk("div1_tick", 32'(dtick_b), 32'(tick_at(n, 1)));
      chk("lfsr5", 32'(data_b), m5);
      chk("done5", 32'(done_b), 32'(m5 == 32'(seed5)));
   endtask
   initial begin
      logic found;
      logic [31:0] frozen;
      logic [31:0] seen;
      int steps, first_done, distinct;
      repeat (3) cyc();
      chk("rst_lfsr", 32'(data_a), 32'h0);
      chk("rst_pix", 32'(pix_a), 32'h0);
      reset = 1'b0;
      repeat (12) cyc();
      lfsr_en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         cyc();
         found = m25 == 32'h7;
      end
      chk("step_to_7_seen", 32'(found), 32'h1);
      chk("step_to_7", 32'(data_a), 32'h0000007);
      seed25 = 25'(clk_rand_core_pkg::SEED);
      seed_dv = 1'b1;
      cyc();
      seed_dv = 1'b0;
      chk("seed_load", 32'(data_a), 32'h1D1745F);
      chk("seed_done", 32'(done_a), 32'h1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cyc();
         found = m25 != 32'h1D1745F;
      end
      chk("seed_step_seen", 32'(found), 32'h1);
      chk("seed_step", 32'(data_a), 32'h1A2E8BE);
      chk("seed_step_done", 32'(done_a), 32'h0);
      lfsr_en = 1'b0;
      frozen = m25;
      repeat (20) cyc();
      chk("freeze", 32'(data_a), frozen);
      lfsr_en = 1'b1;
      while (!tick_at(n, 3)) cyc();
      seed25 = 25'h0ABCDE;
      seed_dv = 1'b1;
      cyc();
      seed_dv = 1'b0;
      chk("seed_beats_tick", 32'(data_a), 32'h0ABCDE);
      while (n % 3 != 1) cyc();
      reset = 1'b1;
      cyc();
      chk("midrst_div", 32'(dclk_a), 32'h0);
      chk("midrst_lfsr", 32'(data_a), 32'h0);
      reset = 1'b0;
      repeat (2) cyc();
      chk("restart_low", 32'(dclk_a), 32'h0);
      cyc();
      chk("restart_rise", 32'(dclk_a), 32'h1);
      for (int i = 0; i < 300; i++) begin
         lfsr_en = $urandom_range(0, 3) != 0;
         seed_dv = $urandom_range(0, 15) == 0;
         reset   = $urandom_range(0, 63) == 0;
         seed25  = 25'($urandom);
         seed5   = 5'($urandom);
         cyc();
      end
      reset = 1'b0;
      lfsr_en = 1'b0;
      seed5 = 5'd1;
      seed_dv = 1'b1;
      cyc();
      seed_dv = 1'b0;
      lfsr_en = 1'b1;
      seen = '0;
      steps = 0;
      first_done = -1;
      for (int i = 0; i < 200 && first_done < 0; i++) begin
         frozen = m5;
         cyc();
         if (m5 != frozen) begin
            steps++;
            seen[data_b] = 1'b1;
            if (done_b) first_done = steps;
         end
      end
      distinct = 0;
      for (int i = 0; i < 32; i++) distinct += int'(seen[i]);
      chk("period31", 32'(first_done), 32'd31);
      chk("distinct31", 32'(distinct), 32'd31);
      chk("no_lockup", 32'(seen[31]), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
